// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB master state encoding, phase constants and width helpers
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // {psel, penable} per bus phase
  localparam logic [1:0] APB_PH_IDLE   = 2'b00;
  localparam logic [1:0] APB_PH_SETUP  = 2'b10;
  localparam logic [1:0] APB_PH_ACCESS = 2'b11;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int align_bits(input int data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS wait-state counter; hit once TIMEOUT stalled cycles are seen
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic en,
  output logic hit
);

  if (TIMEOUT == 0) begin : g_off
    assign hit = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wcnt_q, wcnt_d;

    // Counter parks at TIMEOUT; the FSM leaves ACCESS on hit anyway.
    always_comb begin
      wcnt_d = wcnt_q;
      if (clear) begin
        wcnt_d = '0;
      end else if (en && (wcnt_q != CW'(TIMEOUT))) begin
        wcnt_d = wcnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        wcnt_q <= '0;
      end else begin
        wcnt_q <= wcnt_d;
      end
    end

    assign hit = (wcnt_q == CW'(TIMEOUT));
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB4 master turning a valid/ready command stream into SETUP/ACCESS transfers
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int ALIGN_CHK = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr,
  output logic [15:0]         err_cnt
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << align_bits(DATA_W)) - 1);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic accept, misaligned, tmo_clear, tmo_en, tmo_hit;

  assign accept     = cmd_valid && (state_q == ST_IDLE);
  assign misaligned = (ALIGN_CHK != 0) && ((cmd_addr & ALIGN_MASK) != '0);
  assign tmo_clear  = (state_d == ST_SETUP);
  assign tmo_en     = (state_q == ST_ACCESS) && !pready;

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (tmo_clear),
    .en    (tmo_en),
    .hit   (tmo_hit)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_valid) state_d = misaligned ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready || tmo_hit) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    err_cnt_d     = err_cnt_q;
    rsp_valid_d   = (state_d == ST_RESP);

    case (state_d)
      ST_SETUP:  {psel_d, penable_d} = APB_PH_SETUP;
      ST_ACCESS: {psel_d, penable_d} = APB_PH_ACCESS;
      default:   {psel_d, penable_d} = APB_PH_IDLE;
    endcase

    // Misaligned commands never touch the bus registers, so paddr etc. keep the last transfer.
    if (accept && !misaligned) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_write ? cmd_wdata : '0;
      pstrb_d  = cmd_write ? cmd_strb : '0;
    end else if (accept) begin
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b0;
    end

    if (state_q == ST_ACCESS) begin
      if (pready) begin
        rsp_rdata_d   = (pwrite_q || pslverr) ? '0 : prdata;
        rsp_err_d     = pslverr;
        rsp_timeout_d = 1'b0;
      end else if (tmo_hit) begin
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b1;
      end
    end

    if ((state_q != ST_RESP) && (state_d == ST_RESP) && rsp_err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - self-checking bench for apb_master_ctrl with a behavioural APB slave
module tb_apb_master_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = '0;
  logic [15:0] err_cnt;

  int total = 0;
  int bad = 0;

  logic [31:0] slv_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [15:0] ref_err_cnt = '0;
  int slv_waits = 0;
  bit slv_hang = 0;
  bit slv_err = 0;
  int acc_cnt = 0;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  apb_master_ctrl #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TMO), .ALIGN_CHK(1)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Slave: inserts slv_waits stall cycles per ACCESS, or stalls forever when slv_hang.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (!slv_hang && acc_cnt >= slv_waits) begin
        pready  = 1'b1;
        pslverr = slv_err;
        prdata  = (pwrite || slv_err) ? 32'h0 : slv_mem[paddr[11:2]];
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      end
      acc_cnt++;
    end else begin
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; acc_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (rstn && psel && penable && pready && pwrite && !pslverr)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) slv_mem[paddr[11:2]][8*b +: 8] <= pwdata[8*b +: 8];
  end

  // Reference: one call per command, in issue order.
  function automatic exp_t model_apply(bit wr, logic [11:0] addr, logic [31:0] wdata,
                                       logic [3:0] strb, int waits, bit hang, bit serr);
    exp_t e;
    if (addr[1:0] != 2'b00) begin
      e.lat = 1; e.rdata = 0; e.err = 1; e.tmo = 0;
    end else if (hang || waits > TMO) begin
      e.lat = 3 + TMO; e.rdata = 0; e.err = 1; e.tmo = 1;
    end else begin
      e.lat = 3 + waits; e.err = serr; e.tmo = 0;
      e.rdata = (wr || serr) ? 32'h0 : ref_mem[addr[11:2]];
      if (wr && !serr)
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
    end
    if (e.err && ref_err_cnt != 16'hFFFF) ref_err_cnt = ref_err_cnt + 16'd1;
    return e;
  endfunction

  // Issues one command and observes its response; ends at the negedge after it is consumed.
  task automatic do_cmd(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input bit hang, input bit serr,
                        input int hold, output int lat, output logic [31:0] rdata,
                        output logic err, output logic tmo, output int bus_bad, output int hold_bad);
    int k;
    bit got, mis;
    mis = (addr[1:0] != 2'b00);
    slv_waits = waits; slv_hang = hang; slv_err = serr;
    bus_bad = 0; hold_bad = 0; lat = -1; got = 0;
    rdata = 'x; err = 'x; tmo = 'x;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready) bus_bad++;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; got = 1;
        if (psel || penable) bus_bad++;
      end else if (mis) begin
        if (psel) bus_bad++;
      end else if (c == 1) begin
        if (!(psel && !penable)) bus_bad++;
      end else begin
        if (!(psel && penable)) bus_bad++;
      end
      if (psel && !mis && (paddr !== addr || pwrite !== wr ||
          pwdata !== (wr ? wdata : 32'h0) || pstrb !== (wr ? strb : 4'h0))) bus_bad++;
    end
    if (got) begin
      rdata = rsp_rdata; err = rsp_err; tmo = rsp_timeout;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err ||
            rsp_timeout !== tmo || cmd_ready) hold_bad++;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      if (rsp_valid || !cmd_ready) hold_bad++;
    end
    slv_hang = 0; slv_err = 0; slv_waits = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF;
    repeat (3) @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    total++; if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      bad++; $display("FAIL rst_ctrl: got %b want 000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}); end
    total++; if ({paddr, pwdata, pstrb, rsp_rdata} !== '0) begin
      bad++; $display("FAIL rst_data: paddr=%h pwdata=%h pstrb=%h rdata=%h want 0", paddr, pwdata, pstrb, rsp_rdata); end
    total++; if (err_cnt !== 16'h0) begin bad++; $display("FAIL rst_err_cnt: got %h want 0", err_cnt); end
    cmd_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    total++; if (psel !== 1'b0) begin bad++; $display("FAIL rst_dropped_cmd: psel=%b want 0", psel); end
  endtask

  task automatic test_write_zero_wait();
    exp_t e; int lat, bb, hb; logic [31:0] rd; logic er, tm;
    e = model_apply(1, 12'h000, 32'hA5A5_5A5A, 4'hF, 0, 0, 0);
    do_cmd(1, 12'h000, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 0, lat, rd, er, tm, bb, hb);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr0_latency: got %0d want 3", lat); end
    total++; if (bb !== 0) begin bad++; $display("FAIL wr0_bus_phases: got %0d bad cycles want 0", bb); end
    total++; if (er !== e.err || rd !== e.rdata) begin bad++; $display("FAIL wr0_rsp: err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata); end
    total++; if (slv_mem[0] !== 32'hA5A5_5A5A) begin bad++; $display("FAIL wr0_mem: got %h want a5a55a5a", slv_mem[0]); end
  endtask

  task automatic test_read_waits();
    exp_t e; int lat, bb, hb; logic [31:0] rd; logic er, tm;
    e = model_apply(1, 12'hFFC, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_cmd(1, 12'hFFC, 32'h1234_5678, 4'hF, 0, 0, 0, 0, lat, rd, er, tm, bb, hb);
    e = model_apply(0, 12'hFFC, 32'h0, 4'h0, 3, 0, 0);
    do_cmd(0, 12'hFFC, 32'h0, 4'h0, 3, 0, 0, 0, lat, rd, er, tm, bb, hb);
    total++; if (lat !== 6 || lat !== e.lat) begin bad++; $display("FAIL rd3_latency: got %0d want 6", lat); end
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL rd3_rdata: got %h want 12345678", rd); end
    total++; if (bb !== 0) begin bad++; $display("FAIL rd3_bus_stable: got %0d bad cycles want 0", bb); end
  endtask

  task automatic test_strobe();
    exp_t e; int lat, bb, hb; logic [31:0] rd; logic er, tm;
    e = model_apply(1, 12'h010, 32'hDEAD_BEEF, 4'b0101, 1, 0, 0);
    do_cmd(1, 12'h010, 32'hDEAD_BEEF, 4'b0101, 1, 0, 0, 0, lat, rd, er, tm, bb, hb);
    total++; if (bb !== 0) begin bad++; $display("FAIL strb_bus: got %0d bad cycles want 0", bb); end
    total++; if (slv_mem[4] !== 32'h00AD_00EF) begin bad++; $display("FAIL strb_mem: got %h want 00ad00ef", slv_mem[4]); end
    total++; if (pstrb !== 4'b0101) begin bad++; $display("FAIL strb_held: pstrb=%b want 0101", pstrb); end
  endtask

  task automatic test_timeout();
    exp_t e; int lat, bb, hb; logic [31:0] rd; logic er, tm;
    e = model_apply(0, 12'h100, 32'h0, 4'h0, 0, 1, 0);
    do_cmd(0, 12'h100, 32'h0, 4'h0, 0, 1, 0, 0, lat, rd, er, tm, bb, hb);
    total++; if (lat !== 3 + TMO) begin bad++; $display("FAIL tmo_latency: got %0d want %0d", lat, 3 + TMO); end
    total++; if ({er, tm} !== 2'b11 || rd !== 32'h0) begin bad++; $display("FAIL tmo_rsp: err=%b tmo=%b rdata=%h want 1 1 0", er, tm, rd); end
    total++; if (err_cnt !== 16'd1 || err_cnt !== ref_err_cnt) begin bad++; $display("FAIL tmo_err_cnt: got %0d want 1", err_cnt); end
    e = model_apply(0, 12'hFFC, 32'h0, 4'h0, TMO, 0, 0);
    do_cmd(0, 12'hFFC, 32'h0, 4'h0, TMO, 0, 0, 0, lat, rd, er, tm, bb, hb);
    total++; if (lat !== e.lat || {er, tm} !== 2'b00 || rd !== e.rdata) begin
      bad++; $display("FAIL tmo_edge_ready: lat=%0d err=%b tmo=%b rdata=%h want %0d 0 0 %h", lat, er, tm, rd, e.lat, e.rdata); end
  endtask

  task automatic test_errors();
    exp_t e; int lat, bb, hb; logic [31:0] rd; logic er, tm;
    e = model_apply(1, 12'h002, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    do_cmd(1, 12'h002, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, lat, rd, er, tm, bb, hb);
    total++; if (lat !== 1 || bb !== 0) begin bad++; $display("FAIL align_no_bus: lat=%0d bus_bad=%0d want 1 0", lat, bb); end
    total++; if ({er, tm} !== 2'b10 || rd !== 32'h0) begin bad++; $display("FAIL align_rsp: err=%b tmo=%b rdata=%h want 1 0 0", er, tm, rd); end
    total++; if (paddr !== 12'hFFC) begin bad++; $display("FAIL align_paddr_kept: got %h want ffc", paddr); end
    e = model_apply(0, 12'h000, 32'h0, 4'h0, 2, 0, 1);
    do_cmd(0, 12'h000, 32'h0, 4'h0, 2, 0, 1, 0, lat, rd, er, tm, bb, hb);
    total++; if ({er, tm} !== 2'b10 || lat !== e.lat) begin bad++; $display("FAIL slverr_rsp: err=%b tmo=%b lat=%0d want 1 0 %0d", er, tm, lat, e.lat); end
    total++; if (err_cnt !== ref_err_cnt) begin bad++; $display("FAIL slverr_err_cnt: got %0d want %0d", err_cnt, ref_err_cnt); end
  endtask

  task automatic test_hold_rsp();
    exp_t e; int lat, bb, hb; logic [31:0] rd; logic er, tm;
    e = model_apply(0, 12'h000, 32'h0, 4'h0, 1, 0, 0);
    do_cmd(0, 12'h000, 32'h0, 4'h0, 1, 0, 0, 5, lat, rd, er, tm, bb, hb);
    total++; if (hb !== 0) begin bad++; $display("FAIL hold_stable: got %0d bad cycles want 0", hb); end
    total++; if (rd !== e.rdata) begin bad++; $display("FAIL hold_rdata: got %h want %h", rd, e.rdata); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int acc[5]; int n, cyc; logic [11:0] a; logic [31:0] d;
    int lat, bb, hb; logic [31:0] rd; logic er, tm;
    slv_waits = 0; slv_hang = 0; slv_err = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    a = {$urandom_range(32, 47), 2'b00}; d = $urandom;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_strb = 4'hF;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 60) begin
      if (cmd_ready) begin
        acc[n] = cyc;
        e = model_apply(1, a, d, 4'hF, 0, 0, 0);
        n++;
        @(posedge clk); #1;
        a = {$urandom_range(32, 47), 2'b00}; d = $urandom;
        if (n < 5) begin cmd_addr = a; cmd_wdata = d; end
        else cmd_valid = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
    total++; if (n !== 5 || acc[4] - acc[0] !== 16) begin bad++; $display("FAIL b2b_throughput: accepts=%0d span=%0d want 5 16", n, acc[4] - acc[0]); end
    a = {$urandom_range(32, 47), 2'b00};
    e = model_apply(0, a, 32'h0, 4'h0, 0, 0, 0);
    do_cmd(0, a, 32'h0, 4'h0, 0, 0, 0, 0, lat, rd, er, tm, bb, hb);
    total++; if (rd !== e.rdata || er !== 1'b0) begin bad++; $display("FAIL b2b_readback: got %h want %h", rd, e.rdata); end
  endtask

  task automatic test_random();
    exp_t e; int lat, bb, hb, waits, hold; logic [31:0] rd, d; logic er, tm; logic [11:0] a;
    logic [3:0] s; bit wr, hang, serr;
    for (int i = 0; i < 40; i++) begin
      wr = $urandom_range(0, 1); d = $urandom; s = 4'($urandom_range(0, 15));
      a = {4'h0, 6'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      waits = $urandom_range(0, 4); hang = ($urandom_range(0, 14) == 0);
      serr = ($urandom_range(0, 7) == 0); hold = $urandom_range(0, 2);
      e = model_apply(wr, a, d, s, waits, hang, serr);
      do_cmd(wr, a, d, s, waits, hang, serr, hold, lat, rd, er, tm, bb, hb);
      total++; if (lat !== e.lat) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, e.lat); end
      total++; if (rd !== e.rdata || er !== e.err || tm !== e.tmo) begin
        bad++; $display("FAIL rnd%0d_rsp: rdata=%h err=%b tmo=%b want %h %b %b", i, rd, er, tm, e.rdata, e.err, e.tmo); end
      total++; if (bb !== 0 || hb !== 0) begin bad++; $display("FAIL rnd%0d_protocol: bus_bad=%0d hold_bad=%0d want 0 0", i, bb, hb); end
      total++; if (err_cnt !== ref_err_cnt) begin bad++; $display("FAIL rnd%0d_err_cnt: got %0d want %0d", i, err_cnt, ref_err_cnt); end
    end
  endtask

  task automatic test_reset_in_access();
    int k, seen;
    slv_hang = 1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_wdata = '0; cmd_strb = '0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    k = 0;
    while (!(psel && penable) && k < 10) begin @(negedge clk); k++; end
    total++; if (!(psel && penable)) begin bad++; $display("FAIL rsta_reach_access: psel=%b penable=%b want 1 1", psel, penable); end
    @(negedge clk);
    rstn = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h024; cmd_wdata = 32'h5555_AAAA; cmd_strb = 4'hF;
    @(negedge clk);
    total++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
      bad++; $display("FAIL rsta_abandon: psel/penable/rsp_valid/cmd_ready=%b want 0001", {psel, penable, rsp_valid, cmd_ready}); end
    total++; if (err_cnt !== 16'h0) begin bad++; $display("FAIL rsta_err_cnt: got %0d want 0", err_cnt); end
    @(negedge clk);
    cmd_valid = 1'b0; rstn = 1'b1; ref_err_cnt = '0; slv_hang = 0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (psel || rsp_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rsta_quiet: got %0d active cycles want 0", seen); end
    total++; if (slv_mem[9] !== ref_mem[9]) begin bad++; $display("FAIL rsta_no_write: mem=%h want %h", slv_mem[9], ref_mem[9]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_strobe();
    test_timeout();
    test_errors();
    test_hold_rsp();
    test_back_to_back();
    test_random();
    test_reset_in_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
